// File: rtl/aer_pkg.sv
// Shared widths, packet layout and pack helper for the AER event packer.
package aer_pkg;

  localparam int AER_X_W        = 3;
  localparam int AER_Y_W        = 3;
  localparam int AER_TS_W       = 32;
  localparam int AER_DROP_CNT_W = 16;

  typedef struct packed {
    logic [AER_X_W-1:0]  x;
    logic [AER_Y_W-1:0]  y;
    logic [AER_TS_W-1:0] ts;
    logic                pol;
  } aer_pkt_t;

  function automatic aer_pkt_t aer_pack(
    input logic [AER_X_W-1:0]  x,
    input logic [AER_Y_W-1:0]  y,
    input logic [AER_TS_W-1:0] ts,
    input logic                pol
  );
    aer_pkt_t p;
    p.x   = x;
    p.y   = y;
    p.ts  = ts;
    p.pol = pol;
    return p;
  endfunction

endpackage

// File: rtl/aer_sync_fifo.sv
// Show-ahead sync FIFO: push visible at dout one cycle later, no bypass.
// Push while full and pop while empty are ignored; full/empty use pre-pop state.
module aer_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/aer_event_packer.sv
// Timestamps pixel events and queues {x, y, ts, pol} packets; output 1 cycle after accept.
// DROP_ON_FULL=1 keeps ev_ready_o high and counts drops; 0 backpressures via ev_ready_o.
module aer_event_packer
  import aer_pkg::*;
#(
  parameter int X_W          = AER_X_W,
  parameter int Y_W          = AER_Y_W,
  parameter int TS_W         = AER_TS_W,
  parameter int DEPTH        = 4,
  parameter bit DROP_ON_FULL = 1'b1
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        ev_valid_i,
  output logic                        ev_ready_o,
  input  logic [X_W-1:0]              x_add_i,
  input  logic [Y_W-1:0]              y_add_i,
  input  logic                        polarity_i,
  input  logic                        ts_clr_i,
  output logic [X_W+Y_W+TS_W:0]       data_out_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]  fifo_count_o,
  output logic [AER_DROP_CNT_W-1:0]   drop_cnt_o,
  output logic                        ts_wrap_o
);

  localparam int PW = X_W + Y_W + TS_W + 1;

  typedef struct packed {
    logic [X_W-1:0]  x;
    logic [Y_W-1:0]  y;
    logic [TS_W-1:0] ts;
    logic            pol;
  } pkt_t;

  logic [TS_W-1:0] ts;
  logic            full;
  logic            empty;
  logic            accept;
  logic            drop;
  pkt_t            pkt;

  assign ev_ready_o  = DROP_ON_FULL ? 1'b1 : !full;
  assign accept      = ev_valid_i && ev_ready_o && !full;
  assign drop        = DROP_ON_FULL && ev_valid_i && full;
  assign out_valid_o = !empty;

  always_comb begin
    pkt     = '0;
    pkt.x   = x_add_i;
    pkt.y   = y_add_i;
    pkt.ts  = ts;
    pkt.pol = polarity_i;
  end

  // Clear wins over the wrap so a clear never produces a wrap pulse
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ts        <= '0;
      ts_wrap_o <= 1'b0;
    end else begin
      ts_wrap_o <= !ts_clr_i && (ts == '1);
      ts        <= ts_clr_i ? '0 : ts + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      drop_cnt_o <= '0;
    end else if (drop && (drop_cnt_o != '1)) begin
      drop_cnt_o <= drop_cnt_o + 1'b1;
    end
  end

  aer_sync_fifo #(
    .WIDTH (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push    (accept),
    .din     (pkt),
    .pop     (out_ready_i),
    .dout    (data_out_o),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count_o)
  );

endmodule

// File: tb/tb_aer_event_packer.sv
// Directed + random bench for aer_event_packer: default drop mode (a) and TS_W=4 backpressure mode (b).
module tb_aer_event_packer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  x_add = '0;
  logic [2:0]  y_add = '0;
  logic        pol = 1'b0;
  logic        ev_valid_a = 1'b0, out_ready_a = 1'b0, ts_clr_a = 1'b0;
  logic        ev_valid_b = 1'b0, out_ready_b = 1'b0, ts_clr_b = 1'b0;

  logic        rdy_a, vld_a, wrap_a;
  logic [38:0] data_a;
  logic [2:0]  cnt_a;
  logic [15:0] drop_a;
  logic        rdy_b, vld_b, wrap_b;
  logic [10:0] data_b;
  logic [2:0]  cnt_b;
  logic [15:0] drop_b;

  logic [38:0] qa[$];
  logic [10:0] qb[$];
  logic [31:0] tsa;
  logic [3:0]  tsb;
  int          drops_a;
  logic        wrap_a_exp, wrap_b_exp;
  int          n_assert = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  aer_event_packer u_dut_a (
    .clk_i        (clk),
    .reset_i      (rst),
    .ev_valid_i   (ev_valid_a),
    .ev_ready_o   (rdy_a),
    .x_add_i      (x_add),
    .y_add_i      (y_add),
    .polarity_i   (pol),
    .ts_clr_i     (ts_clr_a),
    .data_out_o   (data_a),
    .out_valid_o  (vld_a),
    .out_ready_i  (out_ready_a),
    .fifo_count_o (cnt_a),
    .drop_cnt_o   (drop_a),
    .ts_wrap_o    (wrap_a)
  );

  aer_event_packer #(
    .TS_W         (4),
    .DROP_ON_FULL (1'b0)
  ) u_dut_b (
    .clk_i        (clk),
    .reset_i      (rst),
    .ev_valid_i   (ev_valid_b),
    .ev_ready_o   (rdy_b),
    .x_add_i      (x_add),
    .y_add_i      (y_add),
    .polarity_i   (pol),
    .ts_clr_i     (ts_clr_b),
    .data_out_o   (data_b),
    .out_valid_o  (vld_b),
    .out_ready_i  (out_ready_b),
    .fifo_count_o (cnt_b),
    .drop_cnt_o   (drop_b),
    .ts_wrap_o    (wrap_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_vld",  64'(vld_a),  64'(qa.size() != 0));
    chk("a_dat",  64'(data_a), (qa.size() != 0) ? 64'(qa[0]) : 64'd0);
    chk("a_cnt",  64'(cnt_a),  64'(qa.size()));
    chk("a_drop", 64'(drop_a), 64'(drops_a));
    chk("a_rdy",  64'(rdy_a),  64'd1);
    chk("a_wrap", 64'(wrap_a), 64'(wrap_a_exp));
    chk("b_vld",  64'(vld_b),  64'(qb.size() != 0));
    chk("b_dat",  64'(data_b), (qb.size() != 0) ? 64'(qb[0]) : 64'd0);
    chk("b_cnt",  64'(cnt_b),  64'(qb.size()));
    chk("b_drop", 64'(drop_b), 64'd0);
    chk("b_rdy",  64'(rdy_b),  64'(qb.size() < DEPTH));
    chk("b_wrap", 64'(wrap_b), 64'(wrap_b_exp));
  endtask

  // Reference: what the coming clock edge does to each instance, then check after it
  task automatic tick();
    bit fa, fb, pa, pb;
    fa = (qa.size() == DEPTH);
    fb = (qb.size() == DEPTH);
    pa = (qa.size() != 0) && out_ready_a;
    pb = (qb.size() != 0) && out_ready_b;
    if (pa) void'(qa.pop_front());
    if (pb) void'(qb.pop_front());
    if (ev_valid_a && !fa) qa.push_back({x_add, y_add, tsa, pol});
    if (ev_valid_a && fa && drops_a < 65535) drops_a++;
    if (ev_valid_b && !fb) qb.push_back({x_add, y_add, tsb, pol});
    wrap_a_exp = !ts_clr_a && (tsa == 32'hFFFF_FFFF);
    wrap_b_exp = !ts_clr_b && (tsb == 4'hF);
    tsa = ts_clr_a ? 32'd0 : tsa + 32'd1;
    tsb = ts_clr_b ? 4'd0 : tsb + 4'd1;
    @(negedge clk);
    check_all();
  endtask

  task automatic set_ev();
    x_add = 3'($urandom_range(0, 7));
    y_add = 3'($urandom_range(0, 7));
    pol   = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_a_vld",  64'(vld_a),  64'd0);
    chk("rst_a_cnt",  64'(cnt_a),  64'd0);
    chk("rst_a_dat",  64'(data_a), 64'd0);
    chk("rst_a_drop", 64'(drop_a), 64'd0);
    chk("rst_b_vld",  64'(vld_b),  64'd0);
    chk("rst_b_cnt",  64'(cnt_b),  64'd0);
    @(negedge clk);
    qa.delete();
    qb.delete();
    tsa = '0;
    tsb = '0;
    drops_a = 0;
    wrap_a_exp = 1'b0;
    wrap_b_exp = 1'b0;
    rst = 1'b0;
    check_all();
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // 1: single event stamped with ts=4, popped straight away
    repeat (4) tick();
    x_add = 3'd1; y_add = 3'd2; pol = 1'b0;
    ev_valid_a = 1'b1; out_ready_a = 1'b1;
    tick();
    ev_valid_a = 1'b0;
    chk("t1_vld", 64'(vld_a), 64'd1);
    chk("t1_dat", 64'(data_a), 64'h14_0000_0008);
    tick();
    chk("t1_empty", 64'(vld_a), 64'd0);
    out_ready_a = 1'b0;

    // 2: fill, drop two, drain in order
    ev_valid_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_ev();
      tick();
    end
    chk("t2_cnt4", 64'(cnt_a), 64'd4);
    for (int i = 0; i < 2; i++) begin
      set_ev();
      tick();
    end
    ev_valid_a = 1'b0;
    chk("t2_drop2", 64'(drop_a), 64'd2);
    chk("t2_cnt_hold", 64'(cnt_a), 64'd4);
    out_ready_a = 1'b1;
    repeat (4) tick();
    chk("t2_drained", 64'(cnt_a), 64'd0);
    out_ready_a = 1'b0;

    // 3: backpressure keeps a held event until space frees up
    ev_valid_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_ev();
      tick();
    end
    chk("t3_rdy_low", 64'(rdy_b), 64'd0);
    x_add = 3'd5; y_add = 3'd6; pol = 1'b1;
    repeat (2) tick();
    chk("t3_cnt_full", 64'(cnt_b), 64'd4);
    out_ready_b = 1'b1;
    tick();
    out_ready_b = 1'b0;
    chk("t3_rdy_high", 64'(rdy_b), 64'd1);
    chk("t3_cnt3", 64'(cnt_b), 64'd3);
    tick();
    ev_valid_b = 1'b0;
    chk("t3_cnt4", 64'(cnt_b), 64'd4);
    chk("t3_drop0", 64'(drop_b), 64'd0);
    out_ready_b = 1'b1;
    repeat (3) tick();
    chk("t3_held_x", 64'(data_b[10:8]), 64'd5);
    tick();
    out_ready_b = 1'b0;

    // 4: 4-bit timestamp wrap pulse and clear behaviour
    for (int i = 0; i < 20 && tsb != 4'hF; i++) tick();
    tick();
    chk("t4_wrap_hi", 64'(wrap_b), 64'd1);
    tick();
    chk("t4_wrap_lo", 64'(wrap_b), 64'd0);
    for (int i = 0; i < 20 && tsb != 4'd9; i++) tick();
    ts_clr_b = 1'b1;
    tick();
    ts_clr_b = 1'b0;
    chk("t4_clr_nowrap", 64'(wrap_b), 64'd0);
    set_ev();
    ev_valid_b = 1'b1;
    tick();
    ev_valid_b = 1'b0;
    chk("t4_clr_ts", 64'(data_b[4:1]), 64'd0);
    out_ready_b = 1'b1;
    repeat (20) tick();
    out_ready_b = 1'b0;

    // 5: steady push+pop at count 2
    ev_valid_a = 1'b1;
    repeat (2) begin
      set_ev();
      tick();
    end
    chk("t5_cnt_start", 64'(cnt_a), 64'd2);
    out_ready_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_ev();
      tick();
      chk("t5_cnt", 64'(cnt_a), 64'd2);
    end
    out_ready_a = 1'b0;
    set_ev();
    tick();
    ev_valid_a = 1'b0;
    chk("t6_cnt3", 64'(cnt_a), 64'd3);

    // 6: async reset mid-stream, then first event stamped near 0
    do_reset();
    set_ev();
    ev_valid_a = 1'b1;
    tick();
    ev_valid_a = 1'b0;
    chk("t6_ts", 64'(data_a[32:1]), 64'd0);

    // Random traffic on both instances
    for (int i = 0; i < 300; i++) begin
      set_ev();
      ev_valid_a  = ($urandom_range(0, 3) != 0);
      ev_valid_b  = ($urandom_range(0, 3) != 0);
      out_ready_a = ($urandom_range(0, 2) == 0);
      out_ready_b = ($urandom_range(0, 2) == 0);
      ts_clr_a    = ($urandom_range(0, 31) == 0);
      ts_clr_b    = ($urandom_range(0, 31) == 0);
      tick();
    end
    ev_valid_a = 1'b0; ev_valid_b = 1'b0;
    ts_clr_a = 1'b0; ts_clr_b = 1'b0;
    out_ready_a = 1'b1; out_ready_b = 1'b1;
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
